ysyx_23060187_ifu: RTL and testbench

YSYX_23060187_IFU -- requirements
Module: ysyx_23060187_ifu

---
 rtl/ysyx_23060187_pkg.sv | 22 ++
 rtl/ysyx_23060187_timeout_cnt.sv | 34 +++
 rtl/ysyx_23060187_ifu.sv | 101 ++++++++++
 tb/tb_ysyx_23060187_ifu.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060187_pkg.sv
// Shared constants and types for the ysyx_23060187 instruction fetch unit.
// Holds the IFU state encoding and the default fetch parameters.
package ysyx_23060187_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int              TIMEOUT_DEFAULT  = 1023;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    DELIVER    = 2'd2,
    EXEC_WAIT  = 2'd3
  } ifu_state_e;

  // Only the two low address bits decide word alignment.
  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060187_timeout_cnt.sv
// Saturating wait-cycle counter for the IFU memory response timeout.
// expired is high during the TIMEOUT-th consecutive enabled cycle.
module ysyx_23060187_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of wait cycles already completed before this one.
  assign expired = (cnt >= LAST);

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Single-outstanding instruction fetch unit: request, wait, deliver, then
// wait for execute to report the next PC before fetching again.
module ysyx_23060187_ifu
  import ysyx_23060187_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_next_pc
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic            pc_aligned;
  logic            timed_out;

  assign pc_aligned   = is_word_aligned(pc[1:0]);
  assign mem_req_addr = pc;
  // Reset is the only input term: the request must drop while reset is held
  // yet be visible in the very first cycle after release.
  assign mem_req_valid = rst && (state == FETCH_REQ) && pc_aligned;

  ysyx_23060187_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != FETCH_WAIT),
    .enable (state == FETCH_WAIT),
    .expired(timed_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FETCH_REQ;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_err   <= 1'b0;
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (!pc_aligned) begin
            state      <= DELIVER;
            inst_valid <= 1'b1;
            inst       <= '0;
            inst_pc    <= pc;
            inst_err   <= 1'b1;
          end else if (mem_req_ready) begin
            state <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          // A response in the expiring cycle still wins over the timeout.
          if (mem_resp_valid) begin
            state      <= DELIVER;
            inst_valid <= 1'b1;
            inst       <= mem_resp_data;
            inst_pc    <= pc;
            inst_err   <= mem_resp_err;
          end else if (timed_out) begin
            state      <= DELIVER;
            inst_valid <= 1'b1;
            inst       <= '0;
            inst_pc    <= pc;
            inst_err   <= 1'b1;
          end
        end
        DELIVER: begin
          if (inst_ready) begin
            state      <= EXEC_WAIT;
            inst_valid <= 1'b0;
          end
        end
        EXEC_WAIT: begin
          if (wb_valid) begin
            state <= FETCH_REQ;
            pc    <= wb_next_pc;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Self-checking bench for ysyx_23060187_ifu: directed fetch scenarios with a
// scoreboard of expected deliveries popped at each decode handshake.
module tb_ysyx_23060187_ifu;

  localparam int          TO     = 8;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        mem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_next_pc = '0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060187_ifu #(
    .RESET_PC(RST_PC),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .mem_resp_err  (mem_resp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err),
    .wb_valid      (wb_valid),
    .wb_next_pc    (wb_next_pc)
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts just after the edge opening the first FETCH_REQ cycle and ends on
  // the falling edge of the first DELIVER cycle. resp_cycle==0 means no response.
  task automatic do_fetch(input logic [31:0] addr, input int stall, input int resp_cycle,
                          input logic [31:0] data, input logic err);
    int   n_wait;
    exp_t e;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) step();
      mem_req_ready = (i == stall);
      @(negedge clk);
      n_cmp++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== addr) begin
        n_bad++;
        $display("FAIL req_hold[%0d]: got valid=%b addr=%h want valid=1 addr=%h",
                 i, mem_req_valid, mem_req_addr, addr);
      end
    end
    n_wait = (resp_cycle > 0) ? resp_cycle : TO;
    if (resp_cycle > 0) e = '{inst: data, pc: addr, err: err};
    else                e = '{inst: 32'h0, pc: addr, err: 1'b1};
    exp_q.push_back(e);
    for (int j = 1; j <= n_wait; j++) begin
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = (resp_cycle > 0) && (j == resp_cycle);
      mem_resp_data  = mem_resp_valid ? data : 32'h0;
      mem_resp_err   = mem_resp_valid ? err : 1'b0;
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_cycle[%0d]: got inst_valid=%b req_valid=%b want 0/0",
                 j, inst_valid, mem_req_valid);
      end
    end
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    mem_resp_err   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL deliver_latency: got inst_valid=%b want 1 (addr %h)", inst_valid, addr);
    end
  endtask

  // Starts on a falling edge in DELIVER; holds inst_ready low for 'hold' cycles,
  // then handshakes and ends on a falling edge in EXEC_WAIT.
  task automatic consume(input int hold);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries want at least 1");
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc || inst_err !== e.err) begin
      n_bad++;
      $display("FAIL deliver: got v=%b inst=%h pc=%h err=%b want v=1 inst=%h pc=%h err=%b",
               inst_valid, inst, inst_pc, inst_err, e.inst, e.pc, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst !== e.inst || inst_pc !== e.pc ||
          inst_err !== e.err || mem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL deliver_hold[%0d]: got v=%b inst=%h pc=%h err=%b req=%b want v=1 inst=%h pc=%h err=%b req=0",
                 i, inst_valid, inst, inst_pc, inst_err, mem_req_valid, e.inst, e.pc, e.err);
      end
    end
    step();
    inst_ready = 1'b1;
    @(negedge clk);
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL exec_wait: got inst_valid=%b req_valid=%b want 0/0", inst_valid, mem_req_valid);
    end
  endtask

  // Pulses wb_valid for one cycle; ends just after the edge opening FETCH_REQ.
  task automatic writeback(input logic [31:0] next_pc);
    step();
    wb_valid   = 1'b1;
    wb_next_pc = next_pc;
    @(negedge clk);
    step();
    wb_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
    end
    n_cmp++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b inst=%h pc=%h err=%b want all zero",
               inst_valid, inst, inst_pc, inst_err);
    end
    n_cmp++;
    if (mem_req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL reset_addr: got %h want %h", mem_req_addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    step();
    rst = 1'b1;
    do_fetch(RST_PC, 0, 1, 32'h0000_0413, 1'b0);
    consume(5);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if (mem_req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL exec_idle[%0d]: got req_valid=%b want 0", i, mem_req_valid);
      end
    end
    writeback(32'h8000_0004);
  endtask

  task automatic test_req_stall();
    do_fetch(32'h8000_0004, 4, 3, 32'h0010_0093, 1'b0);
    consume(0);
    writeback(32'h8000_0008);
  endtask

  task automatic test_resp_err();
    do_fetch(32'h8000_0008, 0, 2, 32'hdead_beef, 1'b1);
    consume(0);
    writeback(32'h8000_000c);
  endtask

  task automatic test_timeout();
    do_fetch(32'h8000_000c, 0, 0, 32'h0, 1'b0);
    consume(0);
    writeback(32'h8000_0010);
    do_fetch(32'h8000_0010, 0, TO, 32'h0020_0113, 1'b0);
    consume(0);
    writeback(32'h8000_0102);
  endtask

  task automatic test_misaligned();
    exp_t e;
    mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misaligned_req: got req_valid=%b want 0", mem_req_valid);
    end
    e = '{inst: 32'h0, pc: 32'h8000_0102, err: 1'b1};
    exp_q.push_back(e);
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    consume(1);
    writeback(32'h8000_0200);
  endtask

  task automatic test_reset_mid_wait();
    mem_req_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0200) begin
      n_bad++;
      $display("FAIL midwait_req: got valid=%b addr=%h want 1/80000200", mem_req_valid, mem_req_addr);
    end
    step();
    mem_req_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midwait_rst_req: got req_valid=%b want 0", mem_req_valid);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || inst_err !== 1'b0 ||
        mem_req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL midwait_rst_outputs: got v=%b inst=%h pc=%h err=%b addr=%h want 0/0/0/0/%h",
               inst_valid, inst, inst_pc, inst_err, mem_req_addr, RST_PC);
    end
    step();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hcafe_f00d;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RST_PC) begin
      n_bad++;
      $display("FAIL midwait_release: got valid=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr, RST_PC);
    end
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    do_fetch(RST_PC, 0, 2, 32'h0030_0193, 1'b0);
  endtask

  task automatic test_ignored();
    step();
    wb_valid       = 1'b1;
    wb_next_pc     = 32'h8000_0300;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hffff_ffff;
    @(negedge clk);
    step();
    wb_valid       = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst !== 32'h0030_0193 || mem_req_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_in_deliver: got v=%b inst=%h req=%b want 1/00300193/0",
               inst_valid, inst, mem_req_valid);
    end
    consume(0);
    writeback(32'h8000_0020);
    mem_req_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0020) begin
      n_bad++;
      $display("FAIL final_req: got valid=%b addr=%h want 1/80000020", mem_req_valid, mem_req_addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_resp_err();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    test_ignored();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
